// File: rtl/addmop_pkg.sv
// addmop_pkg: shared sizing helpers and index types for the AddMop operand
// gatherer. Used by addmop_opgather and addmop_opgather_bank.
package addmop_pkg;

    // Width of a counter that indexes 0..depth-1; never narrower than one bit.
    function automatic int cnt_width(input int depth);
        int w;
        w = $clog2(depth);
        return (w > 1) ? w : 1;
    endfunction

    // Selects one of the two ping-pong banks.
    typedef logic [0:0] bank_idx_t;

    // Slot counter for the default group size; instances with another depth
    // derive their own slot type from cnt_width().
    localparam int DEFAULT_DEPTH = 4;
    typedef logic [cnt_width(DEFAULT_DEPTH)-1:0] slot_t;

endpackage

// File: rtl/addmop_opgather_bank.sv
// addmop_opgather_bank: one ping-pong bank of the operand gatherer.
// Holds depth words of width bits and a full flag. A clear wipes every word
// back to zero so that a short (early-closed) group reads zero in its
// unfilled slots.
module addmop_opgather_bank
    import addmop_pkg::*;
#(
    parameter int width  = 8,
    parameter int depth  = 4,
    parameter int slot_w = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_en,
    input  logic [slot_w-1:0]        slot,
    input  logic [width-1:0]         wr_data,
    input  logic                     set_full,
    input  logic                     clear,
    output logic [depth*width-1:0]   vec,
    output logic                     full
);

    logic [width-1:0] words_reg [depth];
    logic             full_reg;

    generate
        for (genvar gi = 0; gi < depth; gi++) begin : g_word
            // Word gi: zeroed on reset or drain, loaded when its slot is written.
            always_ff @(posedge clk_i) begin
                if (rst_i || clear) begin
                    words_reg[gi] <= '0;
                end else if (wr_en && (slot == slot_w'(gi))) begin
                    words_reg[gi] <= wr_data;
                end
            end

            assign vec[gi*width +: width] = words_reg[gi];
        end
    endgenerate

    // Full flag: set when the group closes, cleared when the consumer drains it.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            full_reg <= 1'b0;
        end else if (set_full) begin
            full_reg <= 1'b1;
        end
    end

    assign full = full_reg;

endmodule

// File: rtl/addmop_opgather.sv
// addmop_opgather: streaming operand gatherer feeding the multi-operand adder.
// Packs depth consecutive width-bit operands into the flat vector out_A_o,
// operand k at bits [k*width +: width]. Two banks ping-pong so one group is
// collected while the previous one waits for the consumer.
// Optional feature macro: ADDMOP_OPGATHER_LAST_EN adds in_last_i, which
// closes a group early; the unfilled slots read as zero.
module addmop_opgather
    import addmop_pkg::*;
#(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [width-1:0]       in_data_i,
`ifdef ADDMOP_OPGATHER_LAST_EN
    input  logic                   in_last_i,
`endif
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [depth*width-1:0] out_A_o
);

    localparam int SLOT_W = cnt_width(depth);
    typedef logic [SLOT_W-1:0] slot_idx_t;
    localparam slot_idx_t LAST_SLOT = slot_idx_t'(depth - 1);

    // The downstream compressor cannot take fewer than four operands.
    generate
        if (depth < 4) begin : g_depth_check
            $error("addmop_opgather: depth must be >= 4");
        end
    endgenerate

    bank_idx_t wr_bank_reg, wr_bank_next;
    bank_idx_t rd_bank_reg, rd_bank_next;
    slot_idx_t slot_reg, slot_next;

    logic [1:0]             bank_full;
    logic [depth*width-1:0] bank_vec [2];

    logic accept;
    logic drain;
    logic close;
    logic last_beat;

`ifdef ADDMOP_OPGATHER_LAST_EN
    assign last_beat = in_last_i;
`else
    assign last_beat = 1'b0;
`endif

    // Ready depends only on registered state so the consumer's ready never
    // reaches back into the producer's handshake.
    assign in_ready_o  = !bank_full[wr_bank_reg];
    assign out_valid_o = bank_full[rd_bank_reg];

    assign accept = in_valid_i && in_ready_o;
    assign drain  = out_valid_o && out_ready_i;
    // A group closes on its last slot, or early on a marked last beat.
    assign close  = accept && ((slot_reg == LAST_SLOT) || last_beat);

    // The read bank may hold a partial group while it is also the write bank,
    // so the output is gated rather than relying on the bank being clear.
    assign out_A_o = out_valid_o ? bank_vec[rd_bank_reg] : '0;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            logic sel_wr;
            logic sel_rd;

            assign sel_wr = (wr_bank_reg == bank_idx_t'(gi));
            assign sel_rd = (rd_bank_reg == bank_idx_t'(gi));

            addmop_opgather_bank #(
                .width  (width),
                .depth  (depth),
                .slot_w (SLOT_W)
            ) u_bank (
                .clk_i    (clk_i),
                .rst_i    (rst_i),
                .wr_en    (accept && sel_wr),
                .slot     (slot_reg),
                .wr_data  (in_data_i),
                .set_full (close && sel_wr),
                .clear    (drain && sel_rd),
                .vec      (bank_vec[gi]),
                .full     (bank_full[gi])
            );
        end
    endgenerate

    // Next-state for the write slot and both bank pointers.
    always_comb begin
        slot_next    = slot_reg;
        wr_bank_next = wr_bank_reg;
        rd_bank_next = rd_bank_reg;

        if (accept) begin
            if (close) begin
                slot_next    = '0;
                wr_bank_next = ~wr_bank_reg;
            end else begin
                slot_next = slot_reg + slot_idx_t'(1);
            end
        end

        if (drain) begin
            rd_bank_next = ~rd_bank_reg;
        end
    end

    // Pointer and slot registers; reset discards any group in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_reg    <= '0;
            wr_bank_reg <= '0;
            rd_bank_reg <= '0;
        end else begin
            slot_reg    <= slot_next;
            wr_bank_reg <= wr_bank_next;
            rd_bank_reg <= rd_bank_next;
        end
    end

endmodule

// File: tb/tb_addmop_opgather.sv
// tb_addmop_opgather: self-checking bench for addmop_opgather (width=8,
// depth=4). The reference model is a queue of completed groups plus the
// group currently being collected; ready/valid expectations follow from how
// many completed groups are waiting.
module tb_addmop_opgather;

    localparam int W = 8;
    localparam int D = 4;
`ifdef ADDMOP_OPGATHER_LAST_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_i;
    logic           in_valid_i;
    logic           in_ready_o;
    logic [W-1:0]   in_data_i;
`ifdef ADDMOP_OPGATHER_LAST_EN
    logic           in_last_i;
`endif
    logic           out_valid_o;
    logic           out_ready_i;
    logic [D*W-1:0] out_A_o;

    always #5 clk = ~clk;

    addmop_opgather #(.width(W), .depth(D)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
`ifdef ADDMOP_OPGATHER_LAST_EN
        .in_last_i   (in_last_i),
`endif
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_A_o     (out_A_o)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    logic [D*W-1:0] grp_q[$];      // completed groups, oldest first
    int             sum_q[$];      // plain sum of each completed group
    logic [D*W-1:0] part_vec;
    int             part_n;
    int             part_sum;
    logic [D*W-1:0] drained_q[$];  // what the DUT handed out, in order
    logic [D*W-1:0] last_a;
    int             n_drained;

    task automatic model_clear();
        grp_q.delete();
        sum_q.delete();
        part_vec = '0;
        part_n   = 0;
        part_sum = 0;
    endtask

    // One clock: drive inputs, check outputs against the model, advance.
    task automatic step(input logic v, input logic [W-1:0] d, input logic r,
                        input logic l, output logic acc);
        logic           exp_rdy;
        logic           exp_vld;
        logic           drn;
        logic [D*W-1:0] exp_a;
        int             s;
        in_valid_i  = v;
        in_data_i   = d;
        out_ready_i = r;
`ifdef ADDMOP_OPGATHER_LAST_EN
        in_last_i   = l;
`endif
        #1;
        exp_rdy = (grp_q.size() < 2);
        exp_vld = (grp_q.size() > 0);
        exp_a   = exp_vld ? grp_q[0] : '0;
        n_vec++;
        if (in_ready_o !== exp_rdy) begin
            n_err++;
            $display("FAIL in_ready: got %b expected %b at %0t", in_ready_o, exp_rdy, $time);
        end
        n_vec++;
        if (out_valid_o !== exp_vld) begin
            n_err++;
            $display("FAIL out_valid: got %b expected %b at %0t", out_valid_o, exp_vld, $time);
        end
        n_vec++;
        if (out_A_o !== exp_a) begin
            n_err++;
            $display("FAIL out_A: got %h expected %h at %0t", out_A_o, exp_a, $time);
        end
        acc = v && exp_rdy;
        drn = exp_vld && r;
        if (drn) begin
            s = 0;
            for (int k = 0; k < D; k++) s += int'(out_A_o[k*W +: W]);
            n_vec++;
            if ((s % 256) !== (sum_q[0] % 256)) begin
                n_err++;
                $display("FAIL adder_sum: got %0d expected %0d at %0t", s % 256, sum_q[0] % 256, $time);
            end
            last_a = out_A_o;
            drained_q.push_back(out_A_o);
            n_drained++;
            $display("group %0d drained: A=%h sum=%0d", n_drained, out_A_o, s % 256);
        end
        @(posedge clk);
        if (drn) begin
            void'(grp_q.pop_front());
            void'(sum_q.pop_front());
        end
        if (acc) begin
            part_vec[part_n*W +: W] = d;
            part_sum += int'(d);
            part_n++;
            if (part_n == D || (LAST_EN && l)) begin
                grp_q.push_back(part_vec);
                sum_q.push_back(part_sum);
                part_vec = '0;
                part_n   = 0;
                part_sum = 0;
            end
        end
        @(negedge clk);
    endtask

    // Offer one operand until it is taken (bounded).
    task automatic send(input logic [W-1:0] d, input logic r, input logic l,
                        output int tries);
        logic acc;
        tries = 0;
        acc   = 1'b0;
        while (!acc && tries < 64) begin
            step(1'b1, d, r, l, acc);
            tries++;
        end
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: operand %h not accepted within 64 cycles", d);
        end
    endtask

    task automatic flush(input int cycles);
        logic acc;
        for (int i = 0; i < cycles; i++) step(1'b0, '0, 1'b1, 1'b0, acc);
    endtask

    task automatic do_reset();
        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        @(posedge clk);
        model_clear();
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_vec++;
        if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready_o); end
        n_vec++;
        if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid_o); end
        n_vec++;
        if (out_A_o !== '0) begin n_err++; $display("FAIL reset_out_A: got %h expected 0", out_A_o); end
        @(negedge clk);
    endtask

    task automatic test_basic();
        int tries;
        int total;
        total = 0;
        for (int i = 1; i <= 4; i++) begin
            send(W'(i), 1'b1, 1'b0, tries);
            total += tries;
        end
        n_vec++;
        if (total !== 4) begin n_err++; $display("FAIL basic_no_stall: took %0d cycles expected 4", total); end
        flush(1);
        n_vec++;
        if (last_a !== 32'h04030201) begin n_err++; $display("FAIL basic_group: got %h expected 04030201", last_a); end
    endtask

    task automatic test_backpressure();
        logic acc;
        int   k;
        int   cyc;
        drained_q.delete();
        k = 1;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, W'(k), 1'b0, 1'b0, acc);
            if (acc) k++;
        end
        n_vec++;
        if (k - 1 !== 8) begin n_err++; $display("FAIL bp_accepted: got %0d expected 8", k - 1); end
        cyc = 0;
        while ((k <= 12 || grp_q.size() != 0) && cyc < 100) begin
            step(k <= 12, W'(k), 1'b1, 1'b0, acc);
            if (acc) k++;
            cyc++;
        end
        n_vec++;
        if (drained_q.size() !== 3) begin
            n_err++;
            $display("FAIL bp_group_count: got %0d expected 3", drained_q.size());
        end else begin
            n_vec++;
            if (drained_q[0] !== 32'h04030201 || drained_q[1] !== 32'h08070605 || drained_q[2] !== 32'h0C0B0A09) begin
                n_err++;
                $display("FAIL bp_order: got %h %h %h expected 04030201 08070605 0C0B0A09",
                         drained_q[0], drained_q[1], drained_q[2]);
            end
        end
    endtask

    task automatic test_stream();
        logic acc;
        int   accepted;
        drained_q.delete();
        accepted = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, W'($urandom), 1'b1, 1'b0, acc);
            if (acc) accepted++;
        end
        n_vec++;
        if (accepted !== 40) begin n_err++; $display("FAIL stream_rate: accepted %0d expected 40", accepted); end
        n_vec++;
        if (drained_q.size() !== 9) begin n_err++; $display("FAIL stream_groups: got %0d expected 9", drained_q.size()); end
        flush(2);
    endtask

    task automatic test_mid_reset();
        int tries;
        send(8'd5, 1'b1, 1'b0, tries);
        send(8'd6, 1'b1, 1'b0, tries);
        do_reset();
        #1;
        n_vec++;
        if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b expected 0", out_valid_o); end
        n_vec++;
        if (out_A_o !== '0) begin n_err++; $display("FAIL midrst_A: got %h expected 0", out_A_o); end
        @(negedge clk);
        for (int i = 9; i <= 12; i++) send(W'(i), 1'b1, 1'b0, tries);
        flush(1);
        n_vec++;
        if (last_a !== 32'h0C0B0A09) begin n_err++; $display("FAIL midrst_group: got %h expected 0C0B0A09", last_a); end
    endtask

    task automatic test_random();
        logic acc;
        logic v;
        logic r;
        logic l;
        int   ops;
        int   cyc;
        ops = 0;
        cyc = 0;
        while (ops < 10000 && cyc < 60000) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            l = LAST_EN && ($urandom_range(0, 7) == 0);
            step(v, W'($urandom), r, l, acc);
            if (acc) ops++;
            cyc++;
        end
        n_vec++;
        if (ops !== 10000) begin n_err++; $display("FAIL random_timeout: accepted %0d of 10000", ops); end
        flush(4);
    endtask

`ifdef ADDMOP_OPGATHER_LAST_EN
    task automatic test_last();
        int tries;
        send(8'd7, 1'b1, 1'b0, tries);
        send(8'd9, 1'b1, 1'b1, tries);
        flush(1);
        n_vec++;
        if (last_a !== 32'h00000907) begin n_err++; $display("FAIL last_group: got %h expected 00000907", last_a); end
        for (int i = 1; i <= 4; i++) send(W'(i), 1'b1, 1'b0, tries);
        flush(1);
        n_vec++;
        if (last_a !== 32'h04030201) begin n_err++; $display("FAIL last_next_group: got %h expected 04030201", last_a); end
    endtask
`endif

    initial begin
        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        out_ready_i = 1'b0;
`ifdef ADDMOP_OPGATHER_LAST_EN
        in_last_i   = 1'b0;
`endif
        last_a    = '0;
        n_drained = 0;
        model_clear();
        test_reset();
        test_basic();
        test_backpressure();
        test_stream();
        test_mid_reset();
`ifdef ADDMOP_OPGATHER_LAST_EN
        test_last();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
